// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit, one outstanding memory access.
//
// Accepts one instruction per cycle while idle. Non-memory instructions pass
// the ALU result straight to writeback with one cycle of latency. Memory
// instructions register a request, hold it stable until mem_ack, and (for
// loads) write back the lane-extracted, sign/zero-extended data one cycle
// after the ack. Misaligned or unsupported accesses, and requests that see
// no ack within MEM_TIMEOUT cycles, set a sticky error flag.
//
// Parameters:
//   MEM_TIMEOUT  cycles in REQ without mem_ack before the access is aborted
//
// Build option:
//   LSU_SUBWORD_EN  when defined, LB/LBU/LH/LHU/SB/SH are memory ops; when
//                   undefined they are rejected with err and no request.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   valid, opcode     instruction valid / opcode (MIPS I-type encodings)
//   addr, wdata       ALU result (address or pass-through) / store data
//   rd_in             writeback destination register
//   stall             upstream must hold inputs while high
//   mem_req, mem_we   memory request / write strobe
//   mem_addr, mem_be  word address / little-endian byte enables
//   mem_wdata         store data, lane-replicated for sub-word stores
//   mem_rdata,mem_ack read data / one-cycle completion pulse
//   wb_valid, wb_data, wb_rd  writeback result
//   err               sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module lsu #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        err
);

   localparam logic [5:0] INST_I_LB  = 6'h20;
   localparam logic [5:0] INST_I_LH  = 6'h21;
   localparam logic [5:0] INST_I_LW  = 6'h23;
   localparam logic [5:0] INST_I_LBU = 6'h24;
   localparam logic [5:0] INST_I_LHU = 6'h25;
   localparam logic [5:0] INST_I_SB  = 6'h28;
   localparam logic [5:0] INST_I_SH  = 6'h29;
   localparam logic [5:0] INST_I_SW  = 6'h2B;

`ifdef LSU_SUBWORD_EN
   localparam bit SUBWORD_EN = 1'b1;
`else
   localparam bit SUBWORD_EN = 1'b0;
`endif

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_e;

   state_e        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          wb_valid_q, wb_valid_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic          err_q, err_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic [4:0]    rd_q, rd_d;
   logic [1:0]    ld_size_q, ld_size_d;
   logic          ld_uns_q, ld_uns_d;
   logic [1:0]    ld_off_q, ld_off_d;

   // decode
   logic        is_word, is_half, is_byte, is_store, is_uns;
   logic        sub_op, unsupported, misaligned, mem_op;
   logic [1:0]  req_size;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   // load data extraction
   logic [31:0] lane;
   logic [31:0] ld_ext;

   always_comb begin
      is_word   = (opcode == INST_I_LW) || (opcode == INST_I_SW);
      is_half   = (opcode == INST_I_LH) || (opcode == INST_I_LHU) || (opcode == INST_I_SH);
      is_byte   = (opcode == INST_I_LB) || (opcode == INST_I_LBU) || (opcode == INST_I_SB);
      is_store  = (opcode == INST_I_SW) || (opcode == INST_I_SH) || (opcode == INST_I_SB);
      is_uns    = (opcode == INST_I_LBU) || (opcode == INST_I_LHU);
      sub_op    = is_half || is_byte;
      unsupported = sub_op && !SUBWORD_EN;
      misaligned  = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
      mem_op      = is_word || (sub_op && SUBWORD_EN);

      req_size  = SZ_W;
      req_be    = 4'b1111;
      req_wdata = wdata;
      if (is_half) begin
         req_size  = SZ_H;
         req_be    = 4'b0011 << addr[1:0];
         req_wdata = {2{wdata[15:0]}};
      end else if (is_byte) begin
         req_size  = SZ_B;
         req_be    = 4'b0001 << addr[1:0];
         req_wdata = {4{wdata[7:0]}};
      end
   end

   // Shift the addressed lane down to bit 0, then extend by access size.
   always_comb begin
      lane = mem_rdata >> {ld_off_q, 3'b000};
      case (ld_size_q)
         SZ_B:    ld_ext = ld_uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         SZ_H:    ld_ext = ld_uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      wb_valid_d  = 1'b0;
      wb_data_d   = wb_data_q;
      wb_rd_d     = wb_rd_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      rd_d        = rd_q;
      ld_size_d   = ld_size_q;
      ld_uns_d    = ld_uns_q;
      ld_off_d    = ld_off_q;

      case (state_q)
         S_IDLE: begin
            if (valid) begin
               if (unsupported || (mem_op && misaligned)) begin
                  err_d = 1'b1;
               end else if (mem_op) begin
                  state_d     = S_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_be_d    = req_be;
                  mem_wdata_d = req_wdata;
                  tmo_d       = '0;
                  rd_d        = rd_in;
                  ld_size_d   = req_size;
                  ld_uns_d    = is_uns;
                  ld_off_d    = addr[1:0];
               end else begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = addr;
                  wb_rd_d    = rd_in;
               end
            end
         end
         S_REQ: begin
            // An ack in the last allowed cycle still completes the access.
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_we_q) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ld_ext;
                  wb_rd_d    = rd_q;
               end
            end else begin
               tmo_d = tmo_q + CW'(1);
               if (tmo_q == CW'(MEM_TIMEOUT - 1)) begin
                  state_d   = S_IDLE;
                  mem_req_d = 1'b0;
                  mem_we_d  = 1'b0;
                  err_d     = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_rd_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
         rd_q        <= '0;
         ld_size_q   <= SZ_W;
         ld_uns_q    <= 1'b0;
         ld_off_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         wb_rd_q     <= wb_rd_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         rd_q        <= rd_d;
         ld_size_q   <= ld_size_d;
         ld_uns_q    <= ld_uns_d;
         ld_off_q    <= ld_off_d;
      end
   end

   assign stall     = (state_q == S_REQ) && !mem_ack;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_data   = wb_data_q;
   assign wb_rd     = wb_rd_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu with MEM_TIMEOUT=4.
// Writeback expectations are queued when an instruction is driven and
// matched by a negedge monitor whenever wb_valid is seen.
// ---------------------------------------------------------------------------
module tb_lsu;

   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [4:0]  rd_in;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        err;

   always #5 clk = ~clk;

   lsu #(.MEM_TIMEOUT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .opcode   (opcode),
      .addr     (addr),
      .wdata    (wdata),
      .rd_in    (rd_in),
      .stall    (stall),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_be   (mem_be),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .wb_valid (wb_valid),
      .wb_data  (wb_data),
      .wb_rd    (wb_rd),
      .err      (err)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
   } wb_t;

   wb_t sb[$];
   int  total = 0;
   int  bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      wb_t e;
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", 32'(wb_valid), 0);
         end else begin
            e = sb.pop_front();
            check("wb_data", wb_data, e.data);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      valid  = 1'b1;
      opcode = op;
      addr   = a;
      wdata  = d;
      rd_in  = r;
      @(posedge clk);
      #1;
      valid  = 1'b0;
   endtask

   task automatic ack(input logic [31:0] r);
      mem_ack   = 1'b1;
      mem_rdata = r;
      #1;
      check("stall_on_ack", 32'(stall), 0);
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check("req_drop", 32'(mem_req), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(2);
      rst = 1'b1;
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r);
      wb_t e;
      e.data = d;
      e.rd   = r;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; valid = 1'b0; opcode = '0; addr = '0; wdata = '0;
      rd_in = '0; mem_rdata = '0; mem_ack = 1'b0;
      cyc(2);
      check("rst_req", 32'(mem_req), 0);
      check("rst_be", 32'(mem_be), 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wbv", 32'(wb_valid), 0);
      check("rst_err", 32'(err), 0);
      check("rst_stall", 32'(stall), 0);
      rst = 1'b1;
      cyc(1);

      // pass-through op
      push(32'h0000_1234, 5'd5);
      drive(OP_ADDIU, 32'h1234, 32'h0, 5'd5);
      check("alu_noreq", 32'(mem_req), 0);
      check("alu_stall", 32'(stall), 0);
      cyc(1);

      // LW with ack after three stalled cycles
      push(32'hDEAD_BEEF, 5'd7);
      drive(OP_LW, 32'h100, 32'h0, 5'd7);
      check("lw_addr", mem_addr, 32'h100);
      check("lw_be", 32'(mem_be), 32'hF);
      check("lw_we", 32'(mem_we), 0);
      for (int i = 0; i < 3; i++) begin
         check("lw_stall", 32'(stall), 1);
         check("lw_req", 32'(mem_req), 1);
         cyc(1);
      end
      ack(32'hDEAD_BEEF);
      mem_ack = 1'b1;  // stray ack while idle
      cyc(1);
      mem_ack = 1'b0;
      check("idle_ack_noreq", 32'(mem_req), 0);

      // SW: no writeback
      drive(OP_SW, 32'h200, 32'h1122_3344, 5'd8);
      check("sw_we", 32'(mem_we), 1);
      check("sw_be", 32'(mem_be), 32'hF);
      check("sw_wdata", mem_wdata, 32'h1122_3344);
      ack(32'h0);
      cyc(1);

      // timeout after 4 cycles without ack
      drive(OP_LW, 32'h300, 32'h0, 5'd9);
      for (int i = 0; i < 4; i++) begin
         check("tmo_req", 32'(mem_req), 1);
         cyc(1);
      end
      check("tmo_drop", 32'(mem_req), 0);
      check("tmo_err", 32'(err), 1);
      check("tmo_stall", 32'(stall), 0);
      cyc(1);

      // reset in the 2nd cycle of REQ, late ack ignored
      drive(OP_LW, 32'h400, 32'h0, 5'd10);
      cyc(1);
      rst = 1'b0;
      cyc(1);
      check("rreq_req", 32'(mem_req), 0);
      check("rreq_stall", 32'(stall), 0);
      check("rreq_err", 32'(err), 0);
      rst = 1'b1;
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      check("rreq_late", 32'(mem_req), 0);
      cyc(1);

`ifdef LSU_SUBWORD_EN
      drive(OP_SB, 32'h103, 32'h0000_00A5, 5'd1);
      check("sb_be", 32'(mem_be), 32'h8);
      check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb_addr", mem_addr, 32'h100);
      ack(32'h0);
      push(32'hFFFF_FF80, 5'd11);
      drive(OP_LB, 32'h102, 32'h0, 5'd11);
      check("lb_be", 32'(mem_be), 32'h4);
      ack(32'h0080_FF00);
      push(32'h0000_0080, 5'd12);
      drive(OP_LBU, 32'h102, 32'h0, 5'd12);
      ack(32'h0080_FF00);
      push(32'hFFFF_8001, 5'd13);
      drive(OP_LH, 32'h102, 32'h0, 5'd13);
      check("lh_be", 32'(mem_be), 32'hC);
      ack(32'h8001_0000);
      push(32'h0000_8001, 5'd14);
      drive(OP_LHU, 32'h102, 32'h0, 5'd14);
      ack(32'h8001_0000);
      drive(OP_SH, 32'h102, 32'hABCD_1234, 5'd15);
      check("sh_be", 32'(mem_be), 32'hC);
      check("sh_wdata", mem_wdata, 32'h1234_1234);
      ack(32'h0);
      drive(OP_LH, 32'h101, 32'h0, 5'd16);
      check("lh_mis_req", 32'(mem_req), 0);
      check("lh_mis_err", 32'(err), 1);
`else
      drive(OP_LB, 32'h100, 32'h0, 5'd11);
      check("lb_off_req", 32'(mem_req), 0);
      check("lb_off_err", 32'(err), 1);
      drive(OP_SH, 32'h100, 32'h0, 5'd12);
      check("sh_off_req", 32'(mem_req), 0);
`endif
      cyc(1);

      // misaligned LW, then normal LW
      do_reset();
      check("rst2_err", 32'(err), 0);
      drive(OP_LW, 32'h102, 32'h0, 5'd3);
      check("mis_req", 32'(mem_req), 0);
      check("mis_err", 32'(err), 1);
      push(32'h0102_0304, 5'd3);
      drive(OP_LW, 32'h104, 32'h0, 5'd3);
      check("lw2_req", 32'(mem_req), 1);
      check("lw2_addr", mem_addr, 32'h104);
      ack(32'h0102_0304);
      check("err_sticky", 32'(err), 1);

      cyc(3);
      check("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum number of cycles in REQ without mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 valid  input  1  the instruction in this stage is valid; aligned with the ALU result register.
REQ-005 opcode  input  6  opcode of the instruction; encodings per INST.v (INST_I_LW, INST_I_SW, ...).
REQ-006 addr  input  32  ALU result, used as the effective address or as the pass-through result.
REQ-007 wdata  input  32  store data (rt value).
REQ-008 rd_in  input  5  writeback destination register.
REQ-009 stall  output  1  upstream holds all inputs while high.
REQ-010 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-011 mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-012 mem_be  output  4  byte enables, little-endian.
REQ-013 mem_wdata  output  32  store data.
REQ-014 mem_rdata  input  32; mem_ack  input  1  read data and one-cycle completion pulse.
REQ-015 wb_valid  output  1; wb_data  output  32; wb_rd  output  5  writeback result.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 The FSM SHALL have two states: IDLE and REQ. Inputs SHALL be sampled only in IDLE.
REQ-018 IDLE, valid, non-memory opcode: on the next cycle, wb_valid=1 for exactly one cycle, wb_data=addr, wb_rd=rd_in (latency 1).
REQ-019 IDLE, valid, aligned memory opcode: on the next edge, the FSM SHALL enter REQ and register mem_req=1, mem_addr, mem_be, mem_we, and mem_wdata.
REQ-020 mem_req and all mem_* outputs SHALL stay stable in REQ until the cycle mem_ack=1. mem_req SHALL drop on the following edge and the FSM SHALL return to IDLE.
REQ-021 stall SHALL equal (state==REQ && !mem_ack), combinationally, so the next instruction is accepted in the cycle after the ack.
REQ-022 Load completion: on the edge where mem_ack=1, the block SHALL capture mem_rdata, extend it per REQ-025, and assert wb_valid for one cycle on the following cycle with wb_rd from the latched rd_in.
REQ-023 Store completion SHALL NOT produce wb_valid.
REQ-024 Misaligned access SHALL issue no request and no wb_valid, set err, and leave the FSM in IDLE. Misaligned means: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
REQ-025 Lane rules:
  - SW/LW: be=4'b1111.
  - SB: be=4'b0001<<addr[1:0], wdata byte replicated x4.
  - SH: be=4'b0011<<addr[1:0], wdata halfword replicated x2.
  - LB/LH: sign-extend the selected byte/halfword.
  - LBU/LHU: zero-extend it.
REQ-026 A timeout counter SHALL clear on REQ entry and count each REQ cycle without an ack. On reaching MEM_TIMEOUT, mem_req SHALL drop, err SHALL set, no wb_valid SHALL be produced, and the FSM SHALL return to IDLE.
REQ-027 mem_ack while in IDLE SHALL be ignored. valid=0 SHALL produce no activity.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 While rst=0 at a clock edge, the FSM SHALL enter IDLE on that edge and the following outputs SHALL be 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, err, and the timeout counter.
REQ-030 Reset during REQ SHALL abandon the access with no writeback. stall SHALL be 0 in the cycle following reset.

Configuration
REQ-031 Macro LSU_SUBWORD_EN:
  - Defined: LB, LBU, LH, LHU, SB, SH SHALL be supported per REQ-024/025.
  - Undefined: only LW and SW are memory ops; the other six opcodes SHALL set err and produce no request and no wb_valid.

Verification
REQ-032 ADDIU-class op, addr=0x1234 -> wb_valid=1 on the next cycle, wb_data=0x00001234, no mem_req.
REQ-033 LW addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_be=4'hF, stall high for 3 cycles, wb_data=0xDEADBEEF one cycle after the ack.
REQ-034 LSU_SUBWORD_EN defined:
  - SB addr=0x103, wdata=0x000000A5 -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, no wb_valid.
  - LB addr=0x102, rdata=0x0080FF00 -> wb_data=0xFFFFFF80.
REQ-035 LW addr=0x102 -> no mem_req, err=1 next cycle; a following valid LW addr=0x104 is served normally.
REQ-036 MEM_TIMEOUT=4, no ack -> mem_req drops after 4 cycles, err=1, no wb_valid.
REQ-037 rst=0 asserted in the 2nd cycle of REQ -> next cycle: mem_req=0, stall=0, err=0; a late mem_ack is ignored.
